fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/if_id_register.sv | 52 +++++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_PARK  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/if_id_register.sv
// Generic stage register: valid, PC and instruction with flush > load > hold priority.
module if_id_register
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule : if_id_register

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch handshake, park buffer and IF/ID register.
// Defining IF_PERF_CNT_EN adds the fetch_count / flush_count performance outputs.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        flush_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  park_pc_q;
    logic [INSTR_W-1:0] park_instr_q;
    logic               park_en;
    logic               ifid_load, ifid_flush;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;

    assign seq_pc = req_addr_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        park_en    = 1'b0;
        ifid_load  = 1'b0;
        ifid_pc    = seq_pc;
        ifid_instr = imem_rdata;
        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d = branch_address;
                    if (imem_ack) req_addr_d = branch_address;
                    else          state_d    = S_DROP;
                end else if (imem_ack) begin
                    pc_d = pc_q + PC_STEP;
                    if (freeze) begin
                        park_en = 1'b1;
                        state_d = S_PARK;
                    end else begin
                        req_addr_d = seq_pc;
                        ifid_load  = 1'b1;
                    end
                end
            end
            S_DROP: begin
                // The stale request must complete before the redirect can be issued.
                if (branch_taken) pc_d = branch_address;
                if (imem_ack) begin
                    req_addr_d = branch_taken ? branch_address : pc_q;
                    state_d    = S_FETCH;
                end
            end
            S_PARK: begin
                ifid_pc    = park_pc_q;
                ifid_instr = park_instr_q;
                if (branch_taken) begin
                    pc_d       = branch_address;
                    req_addr_d = branch_address;
                    state_d    = S_FETCH;
                end else if (!freeze) begin
                    ifid_load  = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // Without a branch, freeze holds IF/ID; otherwise anything not loaded becomes a bubble.
        ifid_flush = branch_taken | (~freeze & ~ifid_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // NOTE: the park buffer is pure datapath qualified by state_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (park_en) begin
            park_pc_q    <= seq_pc;
            park_instr_q <= imem_rdata;
        end
    end

    assign imem_req  = rst_n & (state_q != S_PARK);
    assign imem_addr = req_addr_q;

    if_id_register u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (ifid_pc),
        .instr_i (ifid_instr),
        .valid_o (if_valid),
        .pc_o    (PC),
        .instr_o (Instruction)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (ifid_load)    fetch_count_q <= fetch_count_q + 32'd1;
            if (branch_taken) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b1;
    logic        freeze         = 1'b0;
    logic        branch_taken   = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_ack       = 1'b0;
    logic [31:0] imem_rdata     = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] PC;
    logic [31:0] Instruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: next program-order fetch address, the outstanding request,
    // a one-deep queue of fetched-but-undelivered words, and expected IF/ID contents.
    logic [31:0] next_addr, out_addr, q_pc, q_instr, exp_pc, exp_instr;
    bit          out_active, out_killed, q_full, exp_valid;
    int          lat, waited;
    logic [31:0] exp_fetch_cnt, exp_flush_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .PC             (PC),
        .Instruction    (Instruction)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        next_addr     = RESET_PC;
        out_addr      = '0;
        out_active    = 1'b0;
        out_killed    = 1'b0;
        q_full        = 1'b0;
        q_pc          = '0;
        q_instr       = '0;
        exp_valid     = 1'b0;
        exp_pc        = '0;
        exp_instr     = '0;
        lat           = 0;
        waited        = 0;
        exp_fetch_cnt = '0;
        exp_flush_cnt = '0;
    endtask

    task automatic idle_inputs();
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_PC"},    PC,                32'd0);
        check({tag, "_instr"}, Instruction,       32'd0);
    endtask

    // One cycle, called between edges: check outputs of the last edge, drive this cycle, advance the model.
    task automatic step(input int lat_min, input int lat_max, input int frz_pct, input int br_pct);
        bit          ack, br, frz;
        logic [31:0] ba, rd;
        check("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("PC", PC, exp_pc);
            check("Instruction", Instruction, exp_instr);
        end
`ifdef IF_PERF_CNT_EN
        check("fetch_count", fetch_count, exp_fetch_cnt);
        check("flush_count", flush_count, exp_flush_cnt);
`endif
        check("imem_req", {31'd0, imem_req}, {31'd0, !q_full});
        if (!q_full) begin
            if (!out_active) begin
                out_active = 1'b1;
                out_killed = 1'b0;
                out_addr   = next_addr;
                lat        = int'($urandom_range(lat_max, lat_min));
                waited     = 0;
                check("imem_addr_new", imem_addr, out_addr);
            end else begin
                check("imem_addr_hold", imem_addr, out_addr);
            end
        end

        ack = out_active && (waited == lat);
        br  = ($urandom_range(99) < br_pct);
        frz = ($urandom_range(99) < frz_pct);
        ba  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8
                                       : {22'd0, 8'($urandom_range(255)), 2'b00};
        rd  = $urandom;

        imem_ack       = ack;
        imem_rdata     = rd;
        freeze         = frz;
        branch_taken   = br;
        branch_address = ba;

        if (br) exp_flush_cnt++;
        if (br && out_active) out_killed = 1'b1;
        if (ack) begin
            if (!out_killed) begin
                q_full    = 1'b1;
                q_pc      = out_addr + PC_STEP;
                q_instr   = rd;
                next_addr = out_addr + PC_STEP;
            end
            out_active = 1'b0;
        end else if (out_active) begin
            waited++;
        end

        if (br) begin
            next_addr = ba;
            q_full    = 1'b0;
            exp_valid = 1'b0;
        end else if (!frz) begin
            if (q_full) begin
                exp_valid = 1'b1;
                exp_pc    = q_pc;
                exp_instr = q_instr;
                q_full    = 1'b0;
                exp_fetch_cnt++;
            end else begin
                exp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_model();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Release between edges so the first post-reset cycle is already a modelled one.
        rst_n = 1'b1;
        #1;
        step(0, 0, 0, 0);
        repeat (20)   begin @(negedge clk); step(0, 0, 0, 0);   end
        repeat (30)   begin @(negedge clk); step(2, 2, 0, 0);   end
        repeat (1500) begin @(negedge clk); step(0, 3, 25, 10); end
        repeat (1000) begin @(negedge clk); step(0, 2, 50, 25); end

        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_model();
        rst_n = 1'b1;
        #1;
        step(2, 2, 0, 0);
        for (int i = 0; i < 200 && !(imem_req === 1'b1 && imem_addr === 32'h20); i++) begin
            @(negedge clk);
            step(2, 2, 0, 0);
        end
        check("reach_addr_20", imem_addr, 32'h20);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreq_reset");
        idle_inputs();
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        reset_model();
        rst_n = 1'b1;
        #1;
        check("addr_after_reset", imem_addr, RESET_PC);
        step(0, 3, 20, 10);
        repeat (300) begin @(negedge clk); step(0, 3, 20, 10); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage
